// File: rtl/issue_scoreboard.sv
// issue_scoreboard: one-slot in-order issue stage that stalls on RAW and write-count saturation
// Ports: clock/reset (sync, active-high); decoder side in_valid/in_ready/in_payload/in_rd/in_rs1/in_rs2/*_used;
// execute side out_valid/out_ready/out_payload; wb_valid/wb_rd retire writes; flush drops the held slot;
// busy_mask shows registers with writes in flight; wb_error is a sticky spurious-writeback flag.
// Optional ISSUE_SCOREBOARD_STATS_EN adds stall_cycles and issued_count saturating counters.
module issue_scoreboard #(
  parameter int NUM_REGS     = 16,
  parameter int MAX_INFLIGHT = 3,
  parameter int PAYLOAD_W    = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 in_rd_used,
  input  logic                 in_rs1_used,
  input  logic                 in_rs2_used,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy_mask,
`ifdef ISSUE_SCOREBOARD_STATS_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          issued_count,
`endif
  output logic                 wb_error
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int IW = $clog2(NUM_REGS);
  typedef enum logic {EMPTY, HELD} state_t;
  state_t state_q, state_d;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [IW-1:0] rd_q, rs1_q, rs2_q;
  logic rd_use_q, rs1_use_q, rs2_use_q;
  logic [CW-1:0] pending_q [NUM_REGS];
  logic [CW-1:0] pending_d [NUM_REGS];
  logic err_q, err_d;
  logic full, hazard, issue, accept;
  logic [NUM_REGS-1:0] inc_v, dec_v;
  // x0 and out-of-range indices are never tracked, so they can never stall or count
  function automatic logic trk(input logic [4:0] r);
    return (r != 5'd0) && (32'(r) < NUM_REGS);
  endfunction
  assign full = (state_q == HELD);
  // Hazard looks only at registered counters, so writebacks never reach out_valid combinationally
  assign hazard = (rs1_use_q && pending_q[rs1_q] != '0) ||
                  (rs2_use_q && pending_q[rs2_q] != '0) ||
                  (rd_use_q && pending_q[rd_q] == CW'(MAX_INFLIGHT));
  assign out_valid   = full && !hazard && !flush;
  assign issue       = out_valid && out_ready;
  assign in_ready    = !full || issue || flush;
  assign accept      = in_valid && in_ready;
  assign out_payload = payload_q;
  assign wb_error    = err_q;
  assign inc_v = (issue && rd_use_q) ? (NUM_REGS'(1) << rd_q) : '0;
  assign dec_v = (wb_valid && trk(wb_rd)) ? (NUM_REGS'(1) << wb_rd[IW-1:0]) : '0;
  always_comb begin
    state_d = accept ? HELD : (issue || flush) ? EMPTY : state_q;
  end
  // Issue and writeback to the same register cancel; a writeback to an idle counter flags an error
  always_comb begin
    err_d = err_q | (|(dec_v & ~inc_v & ~busy_mask));
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_mask[i] = pending_q[i] != '0;
      pending_d[i] = (inc_v[i] && !dec_v[i]) ? pending_q[i] + CW'(1) :
                     (dec_v[i] && !inc_v[i] && busy_mask[i]) ? pending_q[i] - CW'(1) : pending_q[i];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= EMPTY;
      err_q     <= 1'b0;
      pending_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      pending_q <= pending_d;
    end
    if (accept) begin
      payload_q <= in_payload;
      rd_q      <= in_rd[IW-1:0];
      rs1_q     <= in_rs1[IW-1:0];
      rs2_q     <= in_rs2[IW-1:0];
      rd_use_q  <= in_rd_used && trk(in_rd);
      rs1_use_q <= in_rs1_used && trk(in_rs1);
      rs2_use_q <= in_rs2_used && trk(in_rs2);
    end
  end
`ifdef ISSUE_SCOREBOARD_STATS_EN
  logic [31:0] stall_q, issued_q;
  assign stall_cycles = stall_q;
  assign issued_count = issued_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      if (full && hazard && ~&stall_q) stall_q <= stall_q + 32'd1;
      if (issue && ~&issued_q) issued_q <= issued_q + 32'd1;
    end
  end
`endif
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue controller between the decode unit and the execute stage. It holds one decoded instruction, tracks outstanding register writes per architectural register (RV32E, x0–x15), and releases the instruction to execute only when none of its source registers has a write in flight. Writeback ports retire pending writes. Execute-side operand reads are therefore always RAW-safe without forwarding.

## Interface
- `NUM_REGS`, 16: tracked architectural registers. Index 0 is never tracked.
- `MAX_INFLIGHT`, 3: maximum outstanding writes per register. Counter width is `$clog2(MAX_INFLIGHT+1)`.
- `PAYLOAD_W`, 128: width of the opaque decoded-instruction payload, passed through unchanged.

- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: decoder offers an instruction.
- `in_ready` output 1: scoreboard accepts this cycle.
- `in_payload` input PAYLOAD_W: decoded instruction.
- `in_rd`, `in_rs1`, `in_rs2` input 5: register indices.
- `in_rd_used`, `in_rs1_used`, `in_rs2_used` input 1: field is meaningful.
- `out_valid` output 1: held instruction is issuable.
- `out_ready` input 1: execute accepts.
- `out_payload` output PAYLOAD_W: held payload.
- `wb_valid` input 1: one register write retires this cycle.
- `wb_rd` input 5: retired register.
- `flush` input 1: discard the held instruction.
- `busy_mask` output NUM_REGS: bit i = pending[i] != 0.
- `wb_error` output 1: sticky; set by a writeback to a register with zero pending writes.

## Operation
- **State:** one holding slot (`full`, payload, indices, used flags) plus `pending[NUM_REGS]` counters.
- **Ignored indices:** index 0 and indices >= NUM_REGS are treated as unused; they are never hazards and never tracked.
- **Slot FSM:** EMPTY -> HELD on accept. HELD -> HELD when a new instruction is accepted in the same cycle as issue. HELD -> EMPTY on issue without a new accept, or on flush.
- **Hazard:** `(rs1_used && pending[rs1]!=0) || (rs2_used && pending[rs2]!=0) || (rd_used && pending[rd]==MAX_INFLIGHT)`. The last term is a saturation stall.
- **Handshakes:**
  - `out_valid = full && !hazard && !flush`.
  - `in_ready = !full || (out_valid && out_ready) || flush`.
- **Issue** (`out_valid && out_ready`): if rd is used, `pending[rd]` increments.
- **Writeback:** `wb_valid` decrements `pending[wb_rd]`. If that counter is 0, it stays 0 and `wb_error` is set.
- **Simultaneous issue and writeback to the same rd:** counter unchanged.
- **Flush:** clears the held instruction only; pending counters are kept, because writes already issued still retire. An accept in the flush cycle is loaded normally.
- **`busy_mask`** is combinational from the counters.
- **Reset values:** full=0, all pending=0, wb_error=0, out_valid=0, in_ready=1 in the first cycle after reset. out_payload is don't-care while out_valid=0.
- **Reset mid-operation** drops the held instruction and all pending counts. Writebacks after reset for pre-reset issues set `wb_error`.

## Timing
- **Accept-to-issue latency:** 1 cycle minimum. An instruction accepted at edge N can be issued with out_valid high in cycle N+1.
- **Hazard evaluation** uses registered counters only. A writeback sampled at edge N clears the hazard; out_valid rises in cycle N+1, never in the writeback cycle itself.
- **Throughput:** 1 instruction/cycle when hazard-free and out_ready is held high.
- **Back-to-back RAW:** a dependent instruction immediately after its producer stalls until the producer's writeback.
- **Stall behaviour:** out_valid may drop while out_ready is low only via flush. Otherwise, once asserted, out_valid and out_payload hold until accepted, because counters only decrease while no issue occurs.
- **No combinational paths:** none from in_valid to in_ready, and none from wb_* to out_valid. There is a combinational path from out_ready and flush to in_ready.

## Configuration
- `ISSUE_SCOREBOARD_STATS_EN`: when defined, adds two output ports, both cleared by reset and saturating at all-ones:
  - `stall_cycles` (32): cycles with `full && hazard`.
  - `issued_count` (32): issues.
- Without the macro, these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- **Reset:** assert reset 2 cycles -> in_ready=1, out_valid=0, busy_mask=0, wb_error=0.
- **Independent stream:** stream `addi x1`, `addi x2`, `addi x3` with out_ready=1 -> one issue per cycle starting the cycle after the first accept; busy_mask=0b1110 after three issues with no writeback.
- **RAW stall:** issue rd=x5, then accept a consumer with rs1=x5 -> out_valid stays 0. Pulse wb_valid with wb_rd=5 at edge N -> out_valid=1 in cycle N+1; busy_mask[5] returns to 0.
- **Saturation and same-cycle update:**
  - Issue three writes to x7 with no writeback -> a fourth rd=x7 instruction stalls.
  - One writeback to x7 -> the fourth instruction issues the next cycle.
  - An issue and a writeback to x7 in the same cycle -> pending[x7] unchanged.
- **x0 and spurious writeback:** an instruction with rs1=x0, rd=x0 issues with no tracking. wb_valid with wb_rd=9 while pending[9]=0 -> wb_error=1 and stays set until reset.
- **Flush and mid-operation reset:**
  - Flush while a stalled instruction is held -> out_valid=0 next cycle; pending counters unchanged; a new accept in the flush cycle is held and issued.
  - Reset while busy_mask is nonzero -> all counters cleared.
